// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shift a byte plus odd parity
// out on device-generated clock edges, check the device ACK, and report done/err.
//
// state     | meaning
// IDLE      | lines released, waiting for tx_start
// INHIBIT   | clock held low for INHIBIT_CYCLES
// RTS       | clock and data low for one cycle (start bit)
// SEND      | data bits, parity and stop driven after each device falling edge
// ACK       | sample device acknowledge on the next falling edge
// WAIT_IDLE | wait for both lines high before signalling done
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_RTS       = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INH_LOAD = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_prev_q;
    logic          fall;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    edge_q, edge_d;
    logic [8:0]    shift_q, shift_d;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic          busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic          timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        edge_d    = edge_q;
        shift_d   = shift_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        timeout   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // a start coinciding with the done pulse is deliberately dropped
                if (tx_start && !done_q) begin
                    shift_d   = {~^tx_data, tx_data};
                    err_d     = 1'b0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    busy_d    = 1'b1;
                    cnt_d     = INH_LOAD;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == '0) begin
                    data_oe_d = 1'b1;
                    state_d   = S_RTS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RTS: begin
                clk_oe_d = 1'b0;
                edge_d   = 4'd0;
                cnt_d    = TMO_LOAD;
                state_d  = S_SEND;
            end
            S_SEND: begin
                if (fall) begin
                    cnt_d  = TMO_LOAD;
                    edge_d = edge_q + 4'd1;
                    if (edge_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                    end
                end else if (cnt_q == '0) begin
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACK: begin
                if (fall) begin
                    cnt_d   = TMO_LOAD;
                    err_d   = data_sync_q[1];
                    state_d = S_WAIT_IDLE;
                end else if (cnt_q == '0) begin
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync_q[1] && data_sync_q[1]) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (fall) begin
                    cnt_d = TMO_LOAD;
                end else if (cnt_q == '0) begin
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (timeout) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            err_d     = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            edge_q    <= 4'd0;
            shift_q   <= 9'd0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            edge_q    <= edge_d;
            shift_q   <= shift_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
endmodule
